// File: rtl/busy_pkg.sv
// Shared constants for the start/busy handshake: FSM encoding, error codes
// and timer width.
package busy_pkg;

  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic ERR_ACK  = 1'b0;
  localparam logic ERR_DONE = 1'b1;

endpackage

// File: rtl/busy_pending_ctr.sv
// Saturating up/down count of queued-but-not-dispatched requests; ready is
// derived from the registered count so it never depends on this cycle's inputs.
module busy_pending_ctr #(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ready
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, matching the synthesized hardware.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else begin
      unique case ({i_inc, i_dec})
        2'b10:   if (!w_full)  r_count <= r_count + 1'b1;
        2'b01:   if (!w_empty) r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_ready = !w_full;

endmodule

// File: rtl/busy_initiator.sv
// Initiator side of the start/busy handshake: queues jobs, pulses start, then
// watches busy rise (ack) and fall (completion) under per-phase timeouts.
module busy_initiator
  import busy_pkg::*;
#(
  parameter  int MAX_PENDING  = 4,
  parameter  int ACK_TIMEOUT  = 4,
  parameter  int DONE_TIMEOUT = 1024,
  localparam int CNT_W        = $clog2(MAX_PENDING + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_busy,
  output logic             o_start,
  output logic             o_done,
  output logic             o_err,
  output logic             o_err_code,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_idle,
  output logic [15:0]      o_jobs
);

  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(DONE_TIMEOUT - 1);

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_start;
  logic             r_done;
  logic             r_err;
  logic             r_err_code;
  logic [15:0]      r_jobs;

  logic             w_accept;
  logic             w_dispatch;
  logic             w_ready;
  logic [CNT_W-1:0] w_pending;

  assign w_accept   = i_req_valid && w_ready;
  // A still-busy peer (late completion or DONE timeout) blocks dispatch.
  assign w_dispatch = (r_state == ST_IDLE) && (w_pending != '0) && !i_busy;

  busy_pending_ctr #(
    .MAX_PENDING (MAX_PENDING),
    .CNT_W       (CNT_W)
  ) u_pending (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_accept),
    .i_dec     (w_dispatch),
    .o_count   (w_pending),
    .o_ready   (w_ready)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_ACK;
      r_jobs     <= '0;
    end else begin
      // Pulses default low; only the deciding transition raises them.
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_dispatch) begin
            r_state <= ST_START;
            r_start <= 1'b1;
          end
        end
        ST_START: begin
          r_timer <= '0;
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (i_busy) begin
            r_state <= ST_WAIT_DONE;
            r_timer <= '0;
          end else if (r_timer == ACK_LAST) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_err      <= 1'b1;
            r_err_code <= ERR_ACK;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!i_busy) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_done  <= 1'b1;
            r_jobs  <= r_jobs + 1'b1;
          end else if (r_timer == DONE_LAST) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_err      <= 1'b1;
            r_err_code <= ERR_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = w_ready;
  assign o_start     = r_start;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;
  assign o_pending   = w_pending;
  assign o_idle      = (r_state == ST_IDLE) && (w_pending == '0);
  assign o_jobs      = r_jobs;

endmodule

// File: tb/tb_busy_initiator.sv
// Directed bench for busy_initiator: a registered busy-counter peer model,
// a cycle table for backpressure, and hand-written timeout/reset sequences.
module tb_busy_initiator;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_busy;
  logic        o_start;
  logic        o_done;
  logic        o_err;
  logic        o_err_code;
  logic [2:0]  o_pending;
  logic        o_idle;
  logic [15:0] o_jobs;

  int n_tests = 0;
  int n_fail  = 0;

  // Peer model: registers start, then holds busy for peer_len cycles.
  int   peer_len = 0;
  int   peer_cnt;
  logic force_busy = 1'b0;

  busy_initiator #(
    .MAX_PENDING  (4),
    .ACK_TIMEOUT  (4),
    .DONE_TIMEOUT (32)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_busy      (i_busy),
    .o_start     (o_start),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .o_pending   (o_pending),
    .o_idle      (o_idle),
    .o_jobs      (o_jobs)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                      peer_cnt <= 0;
    else if (o_start && peer_len > 0)    peer_cnt <= peer_len;
    else if (peer_cnt > 0)               peer_cnt <= peer_cnt - 1;
  end

  assign i_busy = force_busy | (peer_cnt != 0);

  typedef struct {
    logic       valid;
    logic       fbusy;
    logic       exp_ready;
    logic [2:0] exp_pending;
    logic       exp_start;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int k;
    k = 0;
    while (!o_done && k < max_cycles) begin
      tick();
      k++;
    end
    check(name, {31'd0, o_done}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    int dones;

    // Reset state
    #1;
    check("rst_start",   {31'd0, o_start},   32'd0);
    check("rst_pending", {29'd0, o_pending}, 32'd0);
    check("rst_idle",    {31'd0, o_idle},    32'd1);
    check("rst_jobs",    {16'd0, o_jobs},    32'd0);
    repeat (3) tick();
    i_reset_n = 1'b1;
    repeat (2) tick();

    // Single job, peer busy for cycles 3..23
    peer_len = 21;
    i_req_valid = 1'b1;                                        // cycle 0
    check("t1_ready", {31'd0, o_req_ready}, 32'd1);
    tick(); i_req_valid = 1'b0;                                // cycle 1
    check("t1_pend1", {29'd0, o_pending}, 32'd1);
    check("t1_nostart", {31'd0, o_start}, 32'd0);
    tick();                                                    // cycle 2
    check("t1_start", {31'd0, o_start}, 32'd1);
    check("t1_pend0", {29'd0, o_pending}, 32'd0);
    tick();                                                    // cycle 3
    check("t1_start_pulse", {31'd0, o_start}, 32'd0);
    repeat (21) tick();                                        // cycle 24
    check("t1_done_early", {31'd0, o_done}, 32'd0);
    tick();                                                    // cycle 25
    check("t1_done", {31'd0, o_done}, 32'd1);
    check("t1_err",  {31'd0, o_err},  32'd0);
    check("t1_jobs", {16'd0, o_jobs}, 32'd1);
    tick();                                                    // cycle 26
    check("t1_done_pulse", {31'd0, o_done}, 32'd0);
    check("t1_idle", {31'd0, o_idle}, 32'd1);

    // Backpressure with busy forced high, then release
    peer_len = 2;
    vecs[0] = '{1'b1, 1'b1, 1'b1, 3'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1};
    for (int i = 0; i < 8; i++) begin
      i_req_valid = vecs[i].valid;
      force_busy  = vecs[i].fbusy;
      check($sformatf("bp%0d_ready", i),   {31'd0, o_req_ready}, {31'd0, vecs[i].exp_ready});
      check($sformatf("bp%0d_pending", i), {29'd0, o_pending},   {29'd0, vecs[i].exp_pending});
      check($sformatf("bp%0d_start", i),   {31'd0, o_start},     {31'd0, vecs[i].exp_start});
      tick();
    end
    starts = 1;
    dones  = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) starts += int'(o_start);
      dones += int'(o_done);
      if (dones == 4) break;
      tick();
    end
    check("bp_dones",   dones,                4);
    check("bp_starts",  starts,               4);
    check("bp_pending", {29'd0, o_pending},   32'd0);
    check("bp_idle",    {31'd0, o_idle},      32'd1);
    check("bp_jobs",    {16'd0, o_jobs},      32'd5);
    tick();

    // ACK timeout; second request accepted in the dispatch cycle
    peer_len = 0;
    i_req_valid = 1'b1;                                        // cycle 0
    tick();                                                    // cycle 1
    check("ack_pend1", {29'd0, o_pending}, 32'd1);
    tick(); i_req_valid = 1'b0;                                // cycle 2
    check("ack_start", {31'd0, o_start}, 32'd1);
    check("simul_pending", {29'd0, o_pending}, 32'd1);
    for (int c = 3; c <= 6; c++) begin
      tick();
      check($sformatf("ack_noerr_c%0d", c), {31'd0, o_err}, 32'd0);
    end
    tick();                                                    // cycle 7
    check("ack_err",      {31'd0, o_err},      32'd1);
    check("ack_err_code", {31'd0, o_err_code}, 32'd0);
    check("ack_nodone",   {31'd0, o_done},     32'd0);
    check("ack_nostart",  {31'd0, o_start},    32'd0);
    peer_len = 2;
    tick();                                                    // cycle 8
    check("ack_start2",    {31'd0, o_start},   32'd1);
    check("ack_err_pulse", {31'd0, o_err},     32'd0);
    check("ack_pend0",     {29'd0, o_pending}, 32'd0);
    wait_done("ack_done2", 10);
    check("ack_jobs", {16'd0, o_jobs}, 32'd6);
    tick();

    // DONE timeout, busy held c3..c42, queued job waits for busy to fall
    peer_len = 0;
    i_req_valid = 1'b1;                                        // cycle 0
    tick(); i_req_valid = 1'b0;                                // cycle 1
    tick();                                                    // cycle 2
    check("dn_start", {31'd0, o_start}, 32'd1);
    tick(); force_busy = 1'b1; i_req_valid = 1'b1;             // cycle 3
    tick(); i_req_valid = 1'b0;                                // cycle 4
    repeat (31) tick();                                        // cycle 35
    check("dn_noerr_early", {31'd0, o_err}, 32'd0);
    tick();                                                    // cycle 36
    check("dn_err",      {31'd0, o_err},      32'd1);
    check("dn_err_code", {31'd0, o_err_code}, 32'd1);
    check("dn_nodone",   {31'd0, o_done},     32'd0);
    check("dn_jobs",     {16'd0, o_jobs},     32'd6);
    starts = 0;
    for (int c = 37; c <= 42; c++) begin
      tick();
      starts += int'(o_start);
    end
    tick(); force_busy = 1'b0; peer_len = 2;                   // cycle 43
    starts += int'(o_start);
    check("dn_hold_nostart", starts, 0);
    check("dn_hold_pending", {29'd0, o_pending}, 32'd1);
    tick();                                                    // cycle 44
    check("dn_start2", {31'd0, o_start}, 32'd1);
    wait_done("dn_done2", 10);
    check("dn_jobs2",      {16'd0, o_jobs},     32'd7);
    check("dn_code_held",  {31'd0, o_err_code}, 32'd1);
    tick();

    // Asynchronous reset during WAIT_DONE with two queued requests
    peer_len = 0;
    i_req_valid = 1'b1;                                        // cycle 0
    tick(); i_req_valid = 1'b0;                                // cycle 1
    tick();                                                    // cycle 2
    check("rs_start", {31'd0, o_start}, 32'd1);
    tick(); force_busy = 1'b1; i_req_valid = 1'b1;             // cycle 3
    tick();                                                    // cycle 4
    tick(); i_req_valid = 1'b0;                                // cycle 5
    check("rs_pend2", {29'd0, o_pending}, 32'd2);
    #2 i_reset_n = 1'b0;
    #1;
    check("rs_start0",   {31'd0, o_start},    32'd0);
    check("rs_done0",    {31'd0, o_done},     32'd0);
    check("rs_err0",     {31'd0, o_err},      32'd0);
    check("rs_code0",    {31'd0, o_err_code}, 32'd0);
    check("rs_pending0", {29'd0, o_pending},  32'd0);
    check("rs_jobs0",    {16'd0, o_jobs},     32'd0);
    check("rs_idle",     {31'd0, o_idle},     32'd1);
    check("rs_ready",    {31'd0, o_req_ready}, 32'd1);
    force_busy = 1'b0;
    #2 i_reset_n = 1'b1;
    starts = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      starts += int'(o_start);
    end
    check("rs_nostart", starts, 0);
    check("rs_idle2", {31'd0, o_idle}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
